// File: rtl/lane_wb_buffer.sv
// Write-back buffer between a vector lane and the register file. It queues
// {register, data} results and assigns each one its element slot within the destination register.
module lane_wb_buffer #(
    parameter int  VECTOR_REG_WIDTH  = 64,
    parameter int  NUM_OF_VECTOR_REG = 32,
    parameter int  DEPTH             = 4,
    parameter int  VLEN              = 8,
    localparam int REG_AW            = $clog2(NUM_OF_VECTOR_REG),
    localparam int ELEM_W            = $clog2(VLEN)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        result_vld,
    input  logic [REG_AW-1:0]           vec_reg_in,
    input  logic [VECTOR_REG_WIDTH-1:0] data_in,
    output logic                        wb_full_lane,
    output logic                        rf_wr_en,
    output logic [REG_AW-1:0]           rf_wr_addr,
    output logic [ELEM_W-1:0]           rf_wr_elem,
    output logic [VECTOR_REG_WIDTH-1:0] rf_wr_data,
    input  logic                        rf_wr_ready,
    output logic                        reg_done,
    output logic                        overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  ALMOST_CNT = CNT_W'(DEPTH - 1);
    localparam logic [ELEM_W-1:0] LAST_ELEM  = ELEM_W'(VLEN - 1);

    // Entry storage; contents are don't-care after reset, so no reset on the arrays.
    logic [REG_AW-1:0]           reg_mem  [DEPTH];
    logic [VECTOR_REG_WIDTH-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_reg,    wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg,    rd_ptr_next;
    logic [CNT_W-1:0]  count_reg,     count_next;
    logic [ELEM_W-1:0] elem_cnt_reg,  elem_cnt_next;
    logic [REG_AW-1:0] last_reg_reg,  last_reg_next;
    logic              wb_full_reg,   wb_full_next;
    logic              reg_done_reg,  reg_done_next;
    logic              overflow_reg,  overflow_next;

    logic              head_valid;
    logic              pop;
    logic              push;
    logic              reg_switch;
    logic [REG_AW-1:0] head_reg;
    logic [ELEM_W-1:0] write_elem;

    assign head_valid = (count_reg != '0);
    assign head_reg   = reg_mem[rd_ptr_reg];
    assign pop        = head_valid && rf_wr_ready;
    // A full buffer still accepts a result when the head retires on the same edge.
    assign push       = result_vld && ((count_reg != FULL_CNT) || pop);

    // A new destination register mid-count restarts that register at element 0.
    assign reg_switch = (head_reg != last_reg_reg) && (elem_cnt_reg != '0);
    assign write_elem = reg_switch ? '0 : elem_cnt_reg;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        elem_cnt_next = elem_cnt_reg;
        last_reg_next = last_reg_reg;
        overflow_next = overflow_reg;
        reg_done_next = 1'b0;

        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end

        if (pop) begin
            rd_ptr_next   = rd_ptr_reg + 1'b1;
            last_reg_next = head_reg;
            reg_done_next = (write_elem == LAST_ELEM);
            elem_cnt_next = (write_elem == LAST_ELEM) ? '0 : write_elem + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase

        if (result_vld && !push) begin
            overflow_next = 1'b1;
        end

        // Asserted one slot early so a result already in flight from the lane still fits.
        wb_full_next = (count_next >= ALMOST_CNT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            elem_cnt_reg <= '0;
            last_reg_reg <= '0;
            wb_full_reg  <= 1'b0;
            reg_done_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            elem_cnt_reg <= elem_cnt_next;
            last_reg_reg <= last_reg_next;
            wb_full_reg  <= wb_full_next;
            reg_done_reg <= reg_done_next;
            overflow_reg <= overflow_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            reg_mem[wr_ptr_reg]  <= vec_reg_in;
            data_mem[wr_ptr_reg] <= data_in;
        end
    end

    assign rf_wr_en     = head_valid;
    assign rf_wr_addr   = head_reg;
    assign rf_wr_data   = data_mem[rd_ptr_reg];
    assign rf_wr_elem   = write_elem;
    assign wb_full_lane = wb_full_reg;
    assign reg_done     = reg_done_reg;
    assign overflow_err = overflow_reg;

endmodule

// File: tb/tb_lane_wb_buffer.sv
// Self-checking bench for lane_wb_buffer: a directed vector table, hand-written corner
// sequences, and randomized traffic checked against a queue-based reference model.
module tb_lane_wb_buffer;

    localparam int W     = 64;
    localparam int NREG  = 32;
    localparam int DEPTH = 4;
    localparam int VLEN  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          result_vld = 1'b0;
    logic [4:0]    vec_reg_in = '0;
    logic [W-1:0]  data_in = '0;
    logic          rf_wr_ready = 1'b0;
    logic          wb_full_lane;
    logic          rf_wr_en;
    logic [4:0]    rf_wr_addr;
    logic [2:0]    rf_wr_elem;
    logic [W-1:0]  rf_wr_data;
    logic          reg_done;
    logic          overflow_err;

    lane_wb_buffer #(
        .VECTOR_REG_WIDTH (W),
        .NUM_OF_VECTOR_REG(NREG),
        .DEPTH            (DEPTH),
        .VLEN             (VLEN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .result_vld  (result_vld),
        .vec_reg_in  (vec_reg_in),
        .data_in     (data_in),
        .wb_full_lane(wb_full_lane),
        .rf_wr_en    (rf_wr_en),
        .rf_wr_addr  (rf_wr_addr),
        .rf_wr_elem  (rf_wr_elem),
        .rf_wr_data  (rf_wr_data),
        .rf_wr_ready (rf_wr_ready),
        .reg_done    (reg_done),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input bit en, input int addr, input int elem,
                              input logic [63:0] data, input bit full, input bit done, input bit ovf);
        chk({tag, ".rf_wr_en"}, 64'(rf_wr_en), 64'(en));
        if (en) begin
            chk({tag, ".rf_wr_addr"}, 64'(rf_wr_addr), 64'(addr));
            chk({tag, ".rf_wr_elem"}, 64'(rf_wr_elem), 64'(elem));
            chk({tag, ".rf_wr_data"}, rf_wr_data, data);
        end
        chk({tag, ".wb_full_lane"}, 64'(wb_full_lane), 64'(full));
        chk({tag, ".reg_done"}, 64'(reg_done), 64'(done));
        chk({tag, ".overflow_err"}, 64'(overflow_err), 64'(ovf));
    endtask

    // Inputs change at posedge+1; outputs are sampled at the following posedge+1.
    task automatic drive(input bit vld, input int r, input logic [63:0] d, input bit rdy);
        result_vld  = vld;
        vec_reg_in  = 5'(r);
        data_in     = d;
        rf_wr_ready = rdy;
        @(posedge clk);
        #1;
        $display("tx t=%0t vld=%0b reg=%0d data=%0h rdy=%0b -> en=%0b addr=%0d elem=%0d full=%0b done=%0b ovf=%0b",
                 $time, vld, r, d, rdy, rf_wr_en, rf_wr_addr, rf_wr_elem, wb_full_lane, reg_done, overflow_err);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0]  r;
        logic [63:0] d;
    } ent_t;

    ent_t       mq[$];
    int         m_cnt;
    logic [4:0] m_last;
    bit         m_ovf, m_done, m_full;

    task automatic m_reset();
        mq.delete();
        m_cnt  = 0;
        m_last = '0;
        m_ovf  = 0;
        m_done = 0;
        m_full = 0;
    endtask

    function automatic int m_elem();
        if (mq.size() == 0) return 0;
        if (mq[0].r != m_last && m_cnt != 0) return 0;
        return m_cnt;
    endfunction

    task automatic m_step(input bit vld, input int r, input logic [63:0] d, input bit rdy);
        bit   do_pop, do_push;
        int   e;
        ent_t ne;
        do_pop  = (mq.size() != 0) && rdy;
        e       = m_elem();
        do_push = vld && ((mq.size() < DEPTH) || do_pop);
        m_done  = do_pop && (e == VLEN - 1);
        if (do_pop) begin
            m_last = mq[0].r;
            m_cnt  = (e + 1) % VLEN;
            void'(mq.pop_front());
        end
        if (do_push) begin
            ne.r = 5'(r);
            ne.d = d;
            mq.push_back(ne);
        end
        if (vld && !do_push) m_ovf = 1;
        m_full = (mq.size() >= DEPTH - 1);
    endtask

    task automatic apply_reset();
        reset       = 1'b1;
        result_vld  = 1'b0;
        vec_reg_in  = '0;
        data_in     = '0;
        rf_wr_ready = 1'b0;
        @(posedge clk);
        #1;
        expect_out("reset", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        m_reset();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          vld;
        int          r;
        logic [63:0] d;
        bit          rdy;
        bit          en;
        int          addr;
        int          elem;
        logic [63:0] data;
        bit          full;
        bit          done;
        bit          ovf;
    } vec_t;

    function automatic vec_t mk(input bit vld, input int r, input logic [63:0] d, input bit rdy,
                                input bit en, input int addr, input int elem, input logic [63:0] data,
                                input bit full, input bit done, input bit ovf);
        vec_t v;
        v.vld = vld; v.r = r; v.d = d; v.rdy = rdy;
        v.en = en; v.addr = addr; v.elem = elem; v.data = data;
        v.full = full; v.done = done; v.ovf = ovf;
        return v;
    endfunction

    vec_t tbl[13];

    initial begin
        int          cur_reg;
        bit          v, rd;
        int          r;
        logic [63:0] d;
        int          vld_pct[3];
        int          rdy_pct[3];

        // single result, then fill to full with stall, drop, full push+pop, drain
        tbl[0]  = mk(1, 3, 64'hAA, 1,  1, 3, 0, 64'hAA, 0, 0, 0);
        tbl[1]  = mk(0, 0, 64'h0,  1,  0, 0, 0, 64'h0,  0, 0, 0);
        tbl[2]  = mk(1, 4, 64'h11, 0,  1, 4, 0, 64'h11, 0, 0, 0);
        tbl[3]  = mk(1, 4, 64'h22, 0,  1, 4, 0, 64'h11, 0, 0, 0);
        tbl[4]  = mk(1, 4, 64'h33, 0,  1, 4, 0, 64'h11, 1, 0, 0);
        tbl[5]  = mk(1, 4, 64'h44, 0,  1, 4, 0, 64'h11, 1, 0, 0);
        tbl[6]  = mk(1, 4, 64'h55, 0,  1, 4, 0, 64'h11, 1, 0, 1);
        tbl[7]  = mk(0, 0, 64'h0,  0,  1, 4, 0, 64'h11, 1, 0, 1);
        tbl[8]  = mk(1, 4, 64'h66, 1,  1, 4, 1, 64'h22, 1, 0, 1);
        tbl[9]  = mk(0, 0, 64'h0,  1,  1, 4, 2, 64'h33, 1, 0, 1);
        tbl[10] = mk(0, 0, 64'h0,  1,  1, 4, 3, 64'h44, 0, 0, 1);
        tbl[11] = mk(0, 0, 64'h0,  1,  1, 4, 4, 64'h66, 0, 0, 1);
        tbl[12] = mk(0, 0, 64'h0,  1,  0, 0, 0, 64'h0,  0, 0, 1);

        #1;
        expect_out("async_reset", 0, 0, 0, 0, 0, 0, 0);
        apply_reset();

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].vld, tbl[i].r, tbl[i].d, tbl[i].rdy);
            expect_out($sformatf("tbl[%0d]", i), tbl[i].en, tbl[i].addr, tbl[i].elem,
                       tbl[i].data, tbl[i].full, tbl[i].done, tbl[i].ovf);
        end

        // full register of 8 elements, single reg_done, counter back at 0
        apply_reset();
        for (int i = 0; i < VLEN; i++) begin
            drive(1, 5, 64'h500 + 64'(i), 1);
            expect_out($sformatf("fullreg[%0d]", i), 1, 5, i, 64'h500 + 64'(i), 0, 0, 0);
        end
        drive(0, 0, 0, 1);
        expect_out("fullreg.done", 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 1);
        expect_out("fullreg.done_clear", 0, 0, 0, 0, 0, 0, 0);
        drive(1, 5, 64'h5FF, 1);
        expect_out("fullreg.wrap", 1, 5, 0, 64'h5FF, 0, 0, 0);
        drive(0, 0, 0, 1);
        expect_out("fullreg.idle", 0, 0, 0, 0, 0, 0, 0);

        // register switch mid-count
        apply_reset();
        drive(1, 2, 64'h201, 1); expect_out("switch.a", 1, 2, 0, 64'h201, 0, 0, 0);
        drive(1, 2, 64'h202, 1); expect_out("switch.b", 1, 2, 1, 64'h202, 0, 0, 0);
        drive(1, 2, 64'h203, 1); expect_out("switch.c", 1, 2, 2, 64'h203, 0, 0, 0);
        drive(1, 7, 64'h701, 1); expect_out("switch.d", 1, 7, 0, 64'h701, 0, 0, 0);
        drive(1, 7, 64'h702, 1); expect_out("switch.e", 1, 7, 1, 64'h702, 0, 0, 0);
        drive(0, 0, 0, 1);       expect_out("switch.f", 0, 0, 0, 0, 0, 0, 0);

        // full buffer with simultaneous push and pop
        apply_reset();
        for (int i = 1; i <= DEPTH; i++) drive(1, 1, 64'hD0 + 64'(i), 0);
        expect_out("fullpp.filled", 1, 1, 0, 64'hD1, 1, 0, 0);
        drive(1, 1, 64'hD5, 1); expect_out("fullpp.pushpop", 1, 1, 1, 64'hD2, 1, 0, 0);
        drive(1, 1, 64'hD6, 0); expect_out("fullpp.drop", 1, 1, 1, 64'hD2, 1, 0, 1);
        drive(0, 0, 0, 1);      expect_out("fullpp.drain1", 1, 1, 2, 64'hD3, 1, 0, 1);
        drive(0, 0, 0, 1);      expect_out("fullpp.drain2", 1, 1, 3, 64'hD4, 0, 0, 1);
        drive(0, 0, 0, 1);      expect_out("fullpp.drain3", 1, 1, 4, 64'hD5, 0, 0, 1);
        drive(0, 0, 0, 1);      expect_out("fullpp.drain4", 0, 0, 0, 0, 0, 0, 1);

        // reset asserted between edges discards buffered entries and element position
        apply_reset();
        drive(1, 0, 64'hE1, 1); expect_out("midrst.a", 1, 0, 0, 64'hE1, 0, 0, 0);
        drive(1, 0, 64'hE2, 1); expect_out("midrst.b", 1, 0, 1, 64'hE2, 0, 0, 0);
        drive(1, 0, 64'hE3, 0); expect_out("midrst.c", 1, 0, 1, 64'hE2, 0, 0, 0);
        drive(1, 0, 64'hE4, 0);
        drive(1, 0, 64'hE5, 0); expect_out("midrst.d", 1, 0, 1, 64'hE2, 1, 0, 0);
        reset = 1'b1;
        #1;
        expect_out("midrst.async", 0, 0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        drive(1, 0, 64'hE9, 1); expect_out("midrst.after", 1, 0, 0, 64'hE9, 0, 0, 0);
        drive(0, 0, 0, 1);      expect_out("midrst.idle", 0, 0, 0, 0, 0, 0, 0);

        // randomized traffic against the reference model, three load profiles
        vld_pct = '{60, 70, 85};
        rdy_pct = '{85, 50, 30};
        for (int blk = 0; blk < 3; blk++) begin
            apply_reset();
            cur_reg = 0;
            for (int c = 0; c < 250; c++) begin
                v  = ($urandom_range(0, 99) < vld_pct[blk]);
                rd = ($urandom_range(0, 99) < rdy_pct[blk]);
                if ($urandom_range(0, 9) >= 8) cur_reg = $urandom_range(0, 3);
                r  = cur_reg;
                d  = {$urandom, $urandom};
                m_step(v, r, d, rd);
                drive(v, r, d, rd);
                chk("rnd.rf_wr_en", 64'(rf_wr_en), 64'(mq.size() != 0));
                if (mq.size() != 0) begin
                    chk("rnd.rf_wr_addr", 64'(rf_wr_addr), 64'(mq[0].r));
                    chk("rnd.rf_wr_data", rf_wr_data, mq[0].d);
                    chk("rnd.rf_wr_elem", 64'(rf_wr_elem), 64'(m_elem()));
                end
                chk("rnd.wb_full_lane", 64'(wb_full_lane), 64'(m_full));
                chk("rnd.reg_done", 64'(reg_done), 64'(m_done));
                chk("rnd.overflow_err", 64'(overflow_err), 64'(m_ovf));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
